// File: rtl/ulpi_rx_packet_packer.sv
// ULPI receive packet engine: splits RX_CMD from packet bytes, checks PID and CRC16,
// strips the CRC and presents the payload as one held word with valid/ready.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no packet in flight; first packet byte is the PID
// PID     | judge the captured PID; good DATA PID also takes a payload byte
// PAYLOAD | bytes pass through the 2-byte CRC delay line into the buffer
// DONE    | one cycle after EOP: length/CRC verdict and output load
// SKIP    | discard bytes of a rejected or non-DATA packet until EOP
module ulpi_rx_packet_packer #(
  parameter int MAX_PAYLOAD = 8,
  parameter int OUT_W       = 64,
  parameter bit CHECK_CRC   = 1'b1,
  parameter bit STRICT_PID  = 1'b1,
  localparam int LEN_W      = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic             usb_clk,
  input  logic             rst_n,
  input  logic             dir_i,
  input  logic             nxt_i,
  input  logic [7:0]       data_i,
  output logic [OUT_W-1:0] pkt_data_o,
  output logic [LEN_W-1:0] pkt_len_o,
  output logic             pkt_pid_o,
  output logic             pkt_valid_o,
  input  logic             pkt_ready_i,
  output logic [1:0]       linestate_o,
  output logic             disconnect_o,
  output logic             err_o,
  output logic [2:0]       err_code_o
);

  typedef enum logic [2:0] {S_IDLE, S_PID, S_PAYLOAD, S_DONE, S_SKIP} state_t;

  localparam logic [2:0] E_PID = 3'd1, E_CRC = 3'd2, E_SHORT = 3'd3,
                         E_BABBLE = 3'd4, E_RXERR = 3'd5, E_OVF = 3'd6;

  state_t           state_q, state_d;
  logic             dir_q;
  logic [7:0]       pid_q;
  logic [15:0]      crc_q;
  logic [LEN_W-1:0] cnt_q;
  logic [1:0]       dl_cnt_q;
  logic [7:0]       dl_q [2];
  logic [OUT_W-1:0] buf_q;

  logic rx_cmd, pkt_byte, dir_fall, eop, ev_disc, ev_err;
  logic pid_is_data, pid_cmp_ok, babble, short_pkt, crc_bad;
  logic start, shift, load, err_set;
  logic [2:0] err_val;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = b[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return c;
  endfunction

  assign rx_cmd   = dir_i && dir_q && !nxt_i;
  assign pkt_byte = dir_i && dir_q && nxt_i;
  assign dir_fall = !dir_i && dir_q;
  assign eop      = dir_fall || (rx_cmd && data_i[5:4] == 2'b00);
  assign ev_disc  = rx_cmd && data_i[5:4] == 2'b10;
  assign ev_err   = rx_cmd && data_i[5:4] == 2'b11;

  assign pid_is_data = pid_q[2:0] == 3'b011;
  assign pid_cmp_ok  = !STRICT_PID || (pid_q[7:4] == ~pid_q[3:0]);
  // The delay line holds the last two bytes; they only become payload once a third arrives.
  assign babble      = (dl_cnt_q == 2'd2) && (cnt_q == LEN_W'(MAX_PAYLOAD));
  assign short_pkt   = (cnt_q == '0) && (dl_cnt_q != 2'd2);
  assign crc_bad     = CHECK_CRC && (crc_q != 16'h800D);

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    shift   = 1'b0;
    load    = 1'b0;
    err_set = 1'b0;
    err_val = '0;
    case (state_q)
      S_IDLE: if (pkt_byte) begin
        start   = 1'b1;
        state_d = S_PID;
      end
      S_PID: begin
        if (ev_disc) state_d = S_IDLE;
        else if (!pid_cmp_ok) begin
          err_set = 1'b1;
          err_val = E_PID;
          state_d = eop ? S_IDLE : S_SKIP;
        end else if (!pid_is_data) state_d = eop ? S_IDLE : S_SKIP;
        else if (ev_err) begin
          err_set = 1'b1;
          err_val = E_RXERR;
          state_d = S_SKIP;
        end else if (eop) state_d = S_DONE;
        else begin
          shift   = pkt_byte;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (ev_disc) state_d = S_IDLE;
        else if (ev_err) begin
          err_set = 1'b1;
          err_val = E_RXERR;
          state_d = S_SKIP;
        end else if (eop) state_d = S_DONE;
        else if (pkt_byte) begin
          if (babble) begin
            err_set = 1'b1;
            err_val = E_BABBLE;
            state_d = S_SKIP;
          end else shift = 1'b1;
        end
      end
      S_DONE: begin
        if (short_pkt) begin
          err_set = 1'b1;
          err_val = E_SHORT;
        end else if (crc_bad) begin
          err_set = 1'b1;
          err_val = E_CRC;
        end else if (pkt_valid_o && !pkt_ready_i) begin
          err_set = 1'b1;
          err_val = E_OVF;
        end else load = 1'b1;
        state_d = S_IDLE;
        if (pkt_byte) begin
          start   = 1'b1;
          state_d = S_PID;
        end
      end
      S_SKIP: if (ev_disc || eop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q        <= 1'b0;
      pid_q        <= '0;
      crc_q        <= 16'hFFFF;
      cnt_q        <= '0;
      dl_cnt_q     <= '0;
      dl_q[0]      <= '0;
      dl_q[1]      <= '0;
      buf_q        <= '0;
      pkt_data_o   <= '0;
      pkt_len_o    <= '0;
      pkt_pid_o    <= 1'b0;
      pkt_valid_o  <= 1'b0;
      linestate_o  <= '0;
      disconnect_o <= 1'b0;
      err_o        <= 1'b0;
      err_code_o   <= '0;
    end else begin
      dir_q <= dir_i;
      if (rx_cmd) begin
        linestate_o  <= data_i[1:0];
        disconnect_o <= data_i[5:4] == 2'b10;
      end
      if (start) begin
        pid_q    <= data_i;
        crc_q    <= 16'hFFFF;
        cnt_q    <= '0;
        dl_cnt_q <= '0;
        buf_q    <= '0;
      end else if (shift) begin
        crc_q   <= crc16_byte(crc_q, data_i);
        dl_q[1] <= dl_q[0];
        dl_q[0] <= data_i;
        if (dl_cnt_q == 2'd2) begin
          for (int i = 0; i < MAX_PAYLOAD; i++)
            if (cnt_q == LEN_W'(i)) buf_q[i*8 +: 8] <= dl_q[1];
          cnt_q <= cnt_q + LEN_W'(1);
        end else begin
          dl_cnt_q <= dl_cnt_q + 2'd1;
        end
      end
      err_o <= err_set;
      if (err_set) err_code_o <= err_val;
      // A load in the same cycle as a handshake replaces the word and keeps valid high.
      if (load) begin
        pkt_valid_o <= 1'b1;
        pkt_data_o  <= buf_q;
        pkt_len_o   <= cnt_q;
        pkt_pid_o   <= pid_q[3];
      end else if (pkt_ready_i) begin
        pkt_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ulpi_rx_packet_packer.sv
// Randomised and directed bench for ulpi_rx_packet_packer; frames and expected
// outcomes come from a byte-level model (reflected CRC16, packet rules).
module tb_ulpi_rx_packet_packer;
  localparam int MAXP = 8;
  localparam int OW   = 64;
  localparam int LW   = $clog2(MAXP + 1);
  typedef logic [7:0] bq_t[$];

  logic          usb_clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          dir_i = 1'b0, nxt_i = 1'b0, pkt_ready_i = 1'b1;
  logic [7:0]    data_i = 8'h00;
  logic [OW-1:0] pkt_data_o, nc_data;
  logic [LW-1:0] pkt_len_o, nc_len;
  logic          pkt_pid_o, pkt_valid_o, disconnect_o, err_o;
  logic          nc_pid, nc_valid, nc_disc, nc_err;
  logic [1:0]    linestate_o, nc_ls;
  logic [2:0]    err_code_o, nc_code;

  int checks = 0;
  int errors = 0;

  logic [OW-1:0] rx_data_q[$];
  logic [LW-1:0] rx_len_q[$];
  logic          rx_pid_q[$];
  logic [2:0]    err_q[$];
  logic [LW-1:0] nc_len_q[$];

  always #5 usb_clk = ~usb_clk;

  ulpi_rx_packet_packer #(.MAX_PAYLOAD(MAXP), .OUT_W(OW), .CHECK_CRC(1'b1), .STRICT_PID(1'b1)) dut (
    .usb_clk(usb_clk), .rst_n(rst_n), .dir_i(dir_i), .nxt_i(nxt_i), .data_i(data_i),
    .pkt_data_o(pkt_data_o), .pkt_len_o(pkt_len_o), .pkt_pid_o(pkt_pid_o),
    .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i), .linestate_o(linestate_o),
    .disconnect_o(disconnect_o), .err_o(err_o), .err_code_o(err_code_o));

  ulpi_rx_packet_packer #(.MAX_PAYLOAD(MAXP), .OUT_W(OW), .CHECK_CRC(1'b0), .STRICT_PID(1'b1)) dut_nc (
    .usb_clk(usb_clk), .rst_n(rst_n), .dir_i(dir_i), .nxt_i(nxt_i), .data_i(data_i),
    .pkt_data_o(nc_data), .pkt_len_o(nc_len), .pkt_pid_o(nc_pid),
    .pkt_valid_o(nc_valid), .pkt_ready_i(pkt_ready_i), .linestate_o(nc_ls),
    .disconnect_o(nc_disc), .err_o(nc_err), .err_code_o(nc_code));

  always @(negedge usb_clk) begin
    if (rst_n) begin
      if (pkt_valid_o && pkt_ready_i) begin
        rx_data_q.push_back(pkt_data_o);
        rx_len_q.push_back(pkt_len_o);
        rx_pid_q.push_back(pkt_pid_o);
      end
      if (err_o) err_q.push_back(err_code_o);
      if (nc_valid && pkt_ready_i) nc_len_q.push_back(nc_len);
    end
  end

  function automatic logic [15:0] usb_crc(input bq_t b);
    logic [15:0] c = 16'hFFFF;
    foreach (b[i]) begin
      c = c ^ {8'h00, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [OW-1:0] pack(input bq_t b);
    logic [OW-1:0] w = '0;
    foreach (b[i]) if (i < MAXP) w = w | (OW'(b[i]) << (8 * i));
    return w;
  endfunction

  // crc_mode 0: correct CRC, 1: FF FF, 2: correct CRC with one bit flipped
  function automatic bq_t make_frame(input logic [7:0] pid, input bq_t pl, input int crc_mode);
    bq_t f;
    logic [15:0] c;
    c = ~usb_crc(pl);
    if (crc_mode == 1) c = 16'hFFFF;
    else if (crc_mode == 2) c = c ^ (16'h0001 << $urandom_range(15, 0));
    f = pl;
    f.push_front(pid);
    f.push_back(c[7:0]);
    f.push_back(c[15:8]);
    return f;
  endfunction

  task automatic cyc(input logic d, input logic n, input logic [7:0] b);
    dir_i = d; nxt_i = n; data_i = b;
    @(posedge usb_clk); #1;
  endtask

  task automatic clr();
    rx_data_q.delete(); rx_len_q.delete(); rx_pid_q.delete(); err_q.delete(); nc_len_q.delete();
  endtask

  task automatic send_raw(input bq_t fr, input int npre, input bit eop_cmd, input bit mid_cmd);
    cyc(1'b1, 1'b0, 8'h00);
    repeat (npre) cyc(1'b1, 1'b0, 8'h10);
    foreach (fr[i]) begin
      if (mid_cmd && i > 0 && i == fr.size() / 2) cyc(1'b1, 1'b0, 8'h12);
      cyc(1'b1, 1'b1, fr[i]);
    end
    if (eop_cmd) cyc(1'b1, 1'b0, 8'h09);
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #1; rst_n = 1'b0; #1;
    checks++;
    if ({pkt_valid_o, err_o, disconnect_o, linestate_o, err_code_o, pkt_len_o, pkt_pid_o} !== '0) begin
      errors++; $display("FAIL reset_ctrl got %0h want 0",
        {pkt_valid_o, err_o, disconnect_o, linestate_o, err_code_o, pkt_len_o, pkt_pid_o});
    end
    checks++;
    if (pkt_data_o !== '0) begin errors++; $display("FAIL reset_data got %0h want 0", pkt_data_o); end
    repeat (3) @(posedge usb_clk);
    #1; rst_n = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_basic();
    bq_t pl, fr;
    for (int i = 0; i < 5; i++) pl.push_back(8'(8'h11 + i));
    fr = make_frame(8'hC3, pl, 0);
    clr();
    send_raw(fr, 0, 1'b1, 1'b0);
    checks++;
    if (rx_data_q.size() != 1) begin errors++; $display("FAIL t1_count got %0d want 1", rx_data_q.size()); end
    else begin
      checks++;
      if (rx_data_q[0] !== 64'h0000_0015_1413_1211) begin
        errors++; $display("FAIL t1_data got %h want 0000001514131211", rx_data_q[0]);
      end
      checks++;
      if (rx_len_q[0] !== LW'(5) || rx_pid_q[0] !== 1'b0) begin
        errors++; $display("FAIL t1_len_pid got %0d/%0d want 5/0", rx_len_q[0], rx_pid_q[0]);
      end
    end
    checks++;
    if (linestate_o !== 2'b01) begin errors++; $display("FAIL t1_linestate got %0d want 1", linestate_o); end
    checks++;
    if (err_q.size() != 0) begin errors++; $display("FAIL t1_no_err got %0d errs want 0", err_q.size()); end
  endtask

  task automatic test_crc();
    bq_t pl, fr;
    for (int i = 0; i < 5; i++) pl.push_back(8'(8'h11 + i));
    fr = make_frame(8'hC3, pl, 1);
    clr();
    send_raw(fr, 3, 1'b1, 1'b0);
    checks++;
    if (rx_data_q.size() != 0) begin errors++; $display("FAIL t2_dropped got %0d pkts want 0", rx_data_q.size()); end
    checks++;
    if (err_q.size() != 1 || err_q[0] !== 3'd2) begin
      errors++; $display("FAIL t2_err got n=%0d code=%0d want n=1 code=2", err_q.size(), err_q.size() > 0 ? err_q[0] : 3'd0);
    end
    checks++;
    if (nc_len_q.size() != 1 || nc_len_q[0] !== LW'(5)) begin
      errors++; $display("FAIL t2_nocheck got n=%0d want one packet of len 5", nc_len_q.size());
    end
  endtask

  task automatic test_errors();
    bq_t pl, fr;
    logic [2:0] exp;
    for (int k = 0; k < 5; k++) begin
      pl.delete(); fr.delete(); exp = 3'd0;
      case (k)
        0: begin for (int i = 0; i < 9; i++) pl.push_back(8'($urandom)); fr = make_frame(8'h4B, pl, 0); exp = 3'd4; end
        1: begin fr.push_back(8'h4B); fr.push_back(8'h55); exp = 3'd3; end
        2: begin pl.push_back(8'hA1); pl.push_back(8'hA2); fr = make_frame(8'h43, pl, 0); exp = 3'd1; end
        3: fr.push_back(8'hD2);
        default: begin pl.push_back(8'h01); pl.push_back(8'h02); fr = make_frame(8'h69, pl, 0); end
      endcase
      clr();
      send_raw(fr, 0, 1'(k % 2), 1'b0);
      checks++;
      if (rx_data_q.size() != 0) begin errors++; $display("FAIL err_case%0d_pkt got %0d want 0", k, rx_data_q.size()); end
      checks++;
      if (err_q.size() != ((exp != 3'd0) ? 1 : 0) || (exp != 3'd0 && err_q[0] !== exp)) begin
        errors++; $display("FAIL err_case%0d_code got n=%0d want code %0d", k, err_q.size(), exp);
      end
    end
    clr();
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'hC3);
    cyc(1'b1, 1'b1, 8'h11);
    cyc(1'b1, 1'b1, 8'h22);
    cyc(1'b1, 1'b0, 8'h31);
    cyc(1'b1, 1'b1, 8'h33);
    cyc(1'b1, 1'b1, 8'h44);
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
    checks++;
    if (rx_data_q.size() != 0 || err_q.size() != 1 || err_q[0] !== 3'd5) begin
      errors++; $display("FAIL rxerror got pkts=%0d errs=%0d want 0 pkts, code 5", rx_data_q.size(), err_q.size());
    end
  endtask

  task automatic test_boundaries();
    bq_t pl, fr;
    clr();
    fr = make_frame(8'hC3, pl, 0);
    send_raw(fr, 0, 1'b0, 1'b0);
    checks++;
    if (rx_data_q.size() != 1 || rx_len_q[0] !== '0 || rx_data_q[0] !== '0) begin
      errors++; $display("FAIL zero_len got n=%0d want one empty packet", rx_data_q.size());
    end
    for (int i = 0; i < MAXP; i++) pl.push_back(8'($urandom));
    fr = make_frame(8'h4B, pl, 0);
    clr();
    send_raw(fr, 0, 1'b1, 1'b0);
    checks++;
    if (rx_data_q.size() != 1) begin errors++; $display("FAIL max_len_count got %0d want 1", rx_data_q.size()); end
    else if (rx_data_q[0] !== pack(pl) || rx_len_q[0] !== LW'(MAXP) || rx_pid_q[0] !== 1'b1) begin
      errors++; $display("FAIL max_len got %h len %0d want %h len %0d pid 1", rx_data_q[0], rx_len_q[0], pack(pl), MAXP);
    end
  endtask

  task automatic test_hold();
    bq_t pa, pb, fa, fb;
    for (int i = 0; i < 4; i++) pa.push_back(8'($urandom));
    for (int i = 0; i < 3; i++) pb.push_back(8'($urandom));
    fa = make_frame(8'hC3, pa, 0);
    fb = make_frame(8'h4B, pb, 0);
    clr();
    pkt_ready_i = 1'b0;
    send_raw(fa, 0, 1'b0, 1'b0);
    checks++;
    if (pkt_valid_o !== 1'b1 || pkt_data_o !== pack(pa)) begin
      errors++; $display("FAIL hold_first got v=%0d %h want v=1 %h", pkt_valid_o, pkt_data_o, pack(pa));
    end
    send_raw(fb, 0, 1'b1, 1'b0);
    checks++;
    if (pkt_valid_o !== 1'b1 || pkt_data_o !== pack(pa) || pkt_len_o !== LW'(4) || pkt_pid_o !== 1'b0) begin
      errors++; $display("FAIL hold_stable got v=%0d %h len %0d want first packet", pkt_valid_o, pkt_data_o, pkt_len_o);
    end
    checks++;
    if (err_q.size() != 1 || err_q[0] !== 3'd6) begin errors++; $display("FAIL overflow_err got n=%0d want code 6", err_q.size()); end
    pkt_ready_i = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    checks++;
    if (pkt_valid_o !== 1'b0 || rx_data_q.size() != 1) begin
      errors++; $display("FAIL release got v=%0d n=%0d want v=0 n=1", pkt_valid_o, rx_data_q.size());
    end
  endtask

  task automatic test_linestate();
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h20);
    checks++;
    if (disconnect_o !== 1'b1 || linestate_o !== 2'b00) begin
      errors++; $display("FAIL disc_set got d=%0d ls=%0d want 1/0", disconnect_o, linestate_o);
    end
    cyc(1'b1, 1'b0, 8'h01);
    checks++;
    if (disconnect_o !== 1'b0 || linestate_o !== 2'b01) begin
      errors++; $display("FAIL disc_clear got d=%0d ls=%0d want 0/1", disconnect_o, linestate_o);
    end
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    clr();
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'hC3);
    cyc(1'b1, 1'b1, 8'h11);
    cyc(1'b1, 1'b1, 8'h22);
    cyc(1'b1, 1'b0, 8'h22);
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
    checks++;
    if (rx_data_q.size() != 0 || err_q.size() != 0 || disconnect_o !== 1'b1 || linestate_o !== 2'b10) begin
      errors++; $display("FAIL disc_abort got pkts=%0d errs=%0d d=%0d want 0/0/1", rx_data_q.size(), err_q.size(), disconnect_o);
    end
  endtask

  task automatic test_random();
    bq_t pl, fr;
    int n, mode;
    logic [7:0] pid;
    logic [2:0] exp_err;
    for (int t = 0; t < 40; t++) begin
      n    = int'($urandom_range(10, 0));
      pid  = ($urandom_range(1, 0) == 1) ? 8'h4B : 8'hC3;
      mode = ($urandom_range(3, 0) == 0) ? 2 : 0;
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      fr = make_frame(pid, pl, mode);
      if (n > MAXP) exp_err = 3'd4;
      else if (mode != 0) exp_err = 3'd2;
      else exp_err = 3'd0;
      clr();
      send_raw(fr, int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      checks++;
      if (err_q.size() != ((exp_err != 3'd0) ? 1 : 0) || (exp_err != 3'd0 && err_q[0] !== exp_err)) begin
        errors++; $display("FAIL rand%0d_err got n=%0d want code %0d (len %0d)", t, err_q.size(), exp_err, n);
      end
      checks++;
      if (rx_data_q.size() != ((exp_err == 3'd0) ? 1 : 0)) begin
        errors++; $display("FAIL rand%0d_count got %0d pkts (len %0d)", t, rx_data_q.size(), n);
      end else if (exp_err == 3'd0) begin
        checks++;
        if (rx_data_q[0] !== pack(pl) || rx_len_q[0] !== LW'(n) || rx_pid_q[0] !== (pid == 8'h4B)) begin
          errors++; $display("FAIL rand%0d_pkt got %h len %0d pid %0d want %h len %0d", t,
                             rx_data_q[0], rx_len_q[0], rx_pid_q[0], pack(pl), n);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bq_t pl, fr;
    for (int i = 0; i < 3; i++) pl.push_back(8'($urandom));
    fr = make_frame(8'hC3, pl, 0);
    pkt_ready_i = 1'b0;
    send_raw(fr, 0, 1'b1, 1'b0);
    checks++;
    if (pkt_valid_o !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %0d want 1", pkt_valid_o); end
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'hC3);
    cyc(1'b1, 1'b1, 8'hAA);
    cyc(1'b1, 1'b1, 8'hBB);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pkt_valid_o, linestate_o, err_code_o, pkt_len_o, disconnect_o} !== '0 || pkt_data_o !== '0) begin
      errors++; $display("FAIL mid_reset got v=%0d ls=%0d code=%0d want all 0", pkt_valid_o, linestate_o, err_code_o);
    end
    dir_i = 1'b0; nxt_i = 1'b0; data_i = 8'h00;
    repeat (2) @(posedge usb_clk);
    #1; rst_n = 1'b1;
    pkt_ready_i = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    pl.delete();
    for (int i = 0; i < 6; i++) pl.push_back(8'($urandom));
    fr = make_frame(8'h4B, pl, 0);
    clr();
    send_raw(fr, 0, 1'b0, 1'b0);
    checks++;
    if (rx_data_q.size() != 1 || rx_data_q[0] !== pack(pl) || rx_len_q[0] !== LW'(6)) begin
      errors++; $display("FAIL post_reset_pkt got n=%0d want one packet len 6", rx_data_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_crc();
    test_errors();
    test_boundaries();
    test_hold();
    test_linestate();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
